// File: rtl/synth_pkg.sv
// Shared types for the synth chain: step record, sequencer states, tempo default.
package synth_pkg;

  localparam int TONE_W = 4;

  localparam logic [31:0] DEFAULT_STEP_TICKS = 32'd6_000_000;

  typedef struct packed {
    logic              rest;
    logic [TONE_W-1:0] tone;
  } step_t;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } seq_state_t;

endpackage

// File: rtl/note_sequencer_step_timer.sv
// Per-step tick counter: counts 1..S and flags the gate window (count <= G)
// and the last tick of the step; S and G are captured on load.
module step_timer #(
  parameter int TICK_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TICK_W-1:0] step_ticks,
  input  logic [TICK_W-1:0] gate_ticks,
  output logic              gate_window,
  output logic              step_end
);

  logic [TICK_W-1:0] r_count;
  logic [TICK_W-1:0] r_stepLen;
  logic [TICK_W-1:0] r_gateLen;
  logic              r_window;
  logic [TICK_W-1:0] w_stepLen;
  logic [TICK_W-1:0] w_gateLen;

  // S = max(step_ticks,1); G = min(gate_ticks, S-1) so every step ends gate-low
  always_comb begin
    w_stepLen = (step_ticks == '0) ? TICK_W'(1) : step_ticks;
    w_gateLen = (gate_ticks < w_stepLen) ? gate_ticks : (w_stepLen - TICK_W'(1));
  end

  assign step_end    = (r_count == r_stepLen);
  assign gate_window = r_window;

  // Counter parks at S once reached, so an idle timer never wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_stepLen <= '0;
      r_gateLen <= '0;
      r_window  <= 1'b0;
    end else if (load) begin
      r_count   <= TICK_W'(1);
      r_stepLen <= w_stepLen;
      r_gateLen <= w_gateLen;
      r_window  <= (w_gateLen != '0);
    end else if (!step_end) begin
      r_count  <= r_count + TICK_W'(1);
      r_window <= ((r_count + TICK_W'(1)) <= r_gateLen);
    end else begin
      r_window <= 1'b0;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: pattern RAM of {rest, tone} entries played at a runtime tempo,
// driving tone_gen's tone select, a note gate, and the i2s send enable.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int STEPS  = 16,
  parameter int STEP_W = 4,
  parameter int TICK_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  logic [TONE_W-1:0] wr_tone,
  input  logic              wr_rest,
  input  logic [STEP_W-1:0] length,
  input  logic              loop,
  input  logic [TICK_W-1:0] step_ticks,
  input  logic [TICK_W-1:0] gate_ticks,
  input  logic              start,
  input  logic              stop,
  output logic [TONE_W-1:0] tone,
  output logic              gate,
  output logic              send,
  output logic              busy,
  output logic [STEP_W-1:0] step,
  output logic              done
);

  step_t             r_ram [STEPS];
  seq_state_t        r_state;
  logic [TONE_W-1:0] r_tone;
  logic              r_noteOn;
  logic              r_busy;
  logic [STEP_W-1:0] r_step;
  logic              r_done;

  logic              w_load;
  logic [STEP_W-1:0] w_entryAddr;
  step_t             w_entry;
  logic              w_lastStep;
  logic              w_gateWindow;
  logic              w_stepEnd;

  // Entries are read only on step entry; a same-cycle write lands after the read
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) begin
        r_ram[i] <= '{rest: 1'b1, tone: '0};
      end
    end else if (wr_en) begin
      r_ram[wr_addr] <= '{rest: wr_rest, tone: wr_tone};
    end
  end

  assign w_lastStep = (r_step == length);
  assign w_entry    = r_ram[w_entryAddr];

  always_comb begin
    w_load      = 1'b0;
    w_entryAddr = '0;
    case (r_state)
      IDLE: w_load = start && !stop;
      PLAY: begin
        if (!stop && w_stepEnd && (!w_lastStep || loop)) begin
          w_load      = 1'b1;
          w_entryAddr = w_lastStep ? '0 : (r_step + STEP_W'(1));
        end
      end
      default: w_load = 1'b0;
    endcase
  end

  step_timer #(.TICK_W(TICK_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .step_ticks (step_ticks),
    .gate_ticks (gate_ticks),
    .gate_window(w_gateWindow),
    .step_end   (w_stepEnd)
  );

  // tone is left untouched outside step entry so tone_gen's period stays stable
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_tone   <= '0;
      r_noteOn <= 1'b0;
      r_busy   <= 1'b0;
      r_step   <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_load) begin
            r_state  <= PLAY;
            r_step   <= w_entryAddr;
            r_tone   <= w_entry.tone;
            r_noteOn <= !w_entry.rest;
            r_busy   <= 1'b1;
          end
        end
        PLAY: begin
          if (stop) begin
            r_state  <= IDLE;
            r_noteOn <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_load) begin
            r_step   <= w_entryAddr;
            r_tone   <= w_entry.tone;
            r_noteOn <= !w_entry.rest;
          end else if (w_stepEnd && w_lastStep) begin
            r_state  <= DONE;
            r_noteOn <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tone = r_tone;
  assign gate = r_noteOn && w_gateWindow;
  assign busy = r_busy;
  assign send = r_busy;
  assign step = r_step;
  assign done = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized scoreboard bench for note_sequencer against a per-cycle playback model.
module tb_note_sequencer;
  import synth_pkg::*;

  localparam int STEPS  = 16;
  localparam int STEP_W = 4;
  localparam int TICK_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wrEn = 1'b0;
  logic [STEP_W-1:0] wrAddr = '0;
  logic [3:0]        wrTone = '0;
  logic              wrRest = 1'b0;
  logic [STEP_W-1:0] seqLength = '0;
  logic              loopEn = 1'b0;
  logic [TICK_W-1:0] stepTicks = 32'd4;
  logic [TICK_W-1:0] gateTicks = 32'd2;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [3:0]        toneOut;
  logic              gateOut;
  logic              sendOut;
  logic              busyOut;
  logic [STEP_W-1:0] stepOut;
  logic              doneOut;

  always #5 clk = ~clk;

  note_sequencer #(.STEPS(STEPS), .STEP_W(STEP_W), .TICK_W(TICK_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wrEn),
    .wr_addr   (wrAddr),
    .wr_tone   (wrTone),
    .wr_rest   (wrRest),
    .length    (seqLength),
    .loop      (loopEn),
    .step_ticks(stepTicks),
    .gate_ticks(gateTicks),
    .start     (start),
    .stop      (stop),
    .tone      (toneOut),
    .gate      (gateOut),
    .send      (sendOut),
    .busy      (busyOut),
    .step      (stepOut),
    .done      (doneOut)
  );

  typedef struct packed {
    logic [3:0] tone;
    logic       gate;
    logic       busy;
    logic [3:0] step;
    logic       done;
  } obs_t;

  obs_t expQ[$];
  int   total = 0;
  int   bad = 0;

  // Playback model: what a listener would see each cycle
  logic [3:0] mToneRam [STEPS];
  logic       mRestRam [STEPS];
  bit         mPlay = 0;
  bit         mDone = 0;
  bit         mCurRest = 1;
  int         mStep = 0;
  logic [3:0] mTone = '0;
  longint     mElapsed = 0;
  longint     mS = 1;
  longint     mG = 0;

  function void enterStep(input int k);
    mStep    = k;
    mTone    = mToneRam[k];
    mCurRest = mRestRam[k];
    mS       = (stepTicks == 0) ? 1 : longint'(stepTicks);
    mG       = (longint'(gateTicks) < mS) ? longint'(gateTicks) : mS - 1;
    mElapsed = 1;
  endfunction

  task automatic modelStep();
    obs_t o;
    if (reset) begin
      for (int i = 0; i < STEPS; i++) begin
        mToneRam[i] = '0;
        mRestRam[i] = 1'b1;
      end
      mPlay = 0; mDone = 0; mStep = 0; mTone = '0; mCurRest = 1;
      mElapsed = 0; mS = 1; mG = 0;
    end else begin
      if (mDone) mDone = 0;
      else if (!mPlay) begin
        if (start && !stop) begin
          enterStep(0);
          mPlay = 1;
        end
      end
      else if (stop) mPlay = 0;
      else if (mElapsed < mS) mElapsed++;
      else if (mStep != int'(seqLength)) enterStep((mStep + 1) % STEPS);
      else if (loopEn) enterStep(0);
      else begin
        mPlay = 0;
        mDone = 1;
      end
      if (wrEn) begin
        mToneRam[wrAddr] = wrTone;
        mRestRam[wrAddr] = wrRest;
      end
    end
    o.tone = mTone;
    o.gate = mPlay && !mCurRest && (mElapsed <= mG);
    o.busy = mPlay;
    o.step = 4'(mStep);
    o.done = mDone;
    expQ.push_back(o);
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  task automatic checkField(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input obs_t e);
    checkField("tone", int'(toneOut), int'(e.tone));
    checkField("gate", int'(gateOut), int'(e.gate));
    checkField("busy", int'(busyOut), int'(e.busy));
    checkField("send", int'(sendOut), int'(e.busy));
    checkField("step", int'(stepOut), int'(e.step));
    checkField("done", int'(doneOut), int'(e.done));
  endtask

  initial forever begin
    @(negedge clk);
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [3:0] wt,
                               input logic wrs, input logic st, input logic sp);
    wrEn = we; wrAddr = wa; wrTone = wt; wrRest = wrs; start = st; stop = sp;
    @(negedge clk);
  endtask

  task automatic runIdle(input int n);
    repeat (n) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic writeEntry(input int a, input int t, input bit r);
    applyStimulus(1'b1, 4'(a), 4'(t), r, 1'b0, 1'b0);
  endtask

  task automatic setTiming(input int len, input bit lp, input int st, input int gt);
    seqLength = 4'(len); loopEn = lp; stepTicks = 32'(st); gateTicks = 32'(gt);
  endtask

  task automatic pulseStart();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pulseStop();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset during playback");
    writeEntry(0, 4, 0); writeEntry(1, 6, 0);
    setTiming(1, 1, 3, 2);
    pulseStart();
    runIdle(9);
    reset = 1'b1;
    runIdle(1);
    reset = 1'b0;
    setTiming(3, 0, 2, 1);
    pulseStart();
    runIdle(10);

    $display("[TB] basic playback");
    writeEntry(0, 3, 0); writeEntry(1, 7, 0); writeEntry(2, 0, 1); writeEntry(3, 15, 0);
    setTiming(3, 0, 8, 5);
    pulseStart();
    runIdle(40);

    $display("[TB] loop and stop");
    setTiming(1, 1, 4, 2);
    pulseStart();
    runIdle(20);
    pulseStop();
    runIdle(5);

    $display("[TB] degenerate timing");
    setTiming(3, 0, 0, 0);
    pulseStart();
    runIdle(8);
    setTiming(3, 0, 4, 10);
    pulseStart();
    runIdle(20);

    $display("[TB] write hazard");
    writeEntry(1, 5, 0);
    setTiming(1, 1, 4, 3);
    pulseStart();
    runIdle(3);
    writeEntry(1, 9, 0);
    runIdle(12);
    pulseStop();
    runIdle(3);

    $display("[TB] start/stop priority");
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    runIdle(3);
    setTiming(3, 1, 3, 1);
    pulseStart();
    runIdle(4);
    pulseStart();
    runIdle(4);
    pulseStop();
    runIdle(3);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 30; it++) begin
      setTiming($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                $urandom_range(0, 6), $urandom_range(0, 7));
      for (int c = 0; c < 60; c++) begin
        reset = ($urandom_range(0, 199) == 0);
        applyStimulus(1'($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom),
                      1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 49) == 0));
      end
    end
    reset = 1'b0;
    runIdle(5);

    total++;
    if (expQ.size() > 1) begin
      bad++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected at most 1", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
